// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port 24-bit RAM: read bursts stream out through a 2-entry
// skid FIFO, write bursts consume a valid/ready stream. Optional macro: RAM_BURST_BOUND_CHK_EN.
module ram_burst_master #(
    parameter int unsigned AW        = 20,
    parameter int unsigned DW        = 24,
    parameter int unsigned LW        = 16,
    parameter int unsigned MEM_DEPTH = 65536
) (
    input  logic          CK,
    input  logic          RST_N,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          done,
    output logic          err,
    output logic          busy,
    output logic [AW-1:0] A,
    output logic          WE,
    output logic          OE,
    output logic [DW-1:0] D,
    input  logic [DW-1:0] Q
);

    typedef enum logic [2:0] {StIdle, StRd, StRdDrain, StWr, StDone} state_e;

`ifdef RAM_BURST_BOUND_CHK_EN
    localparam bit BoundChk = 1'b1;
`else
    localparam bit BoundChk = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [AW-1:0] a_q, a_d;
    logic          we_q, we_d;
    logic          oe_q, oe_d;
    logic [DW-1:0] d_q, d_d;
    logic          infl_q, infl_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] fifo_q [2];
    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic [1:0]    cnt_q, cnt_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic [2:0]    occ;
    logic          issue;
    logic          wr_fire;
    logic [AW:0]   end_addr;
    logic          oob;

    assign cmd_ready = (state_q == StIdle) && RST_N;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;
    assign A         = a_q;
    assign WE        = we_q;
    assign OE        = oe_q;
    assign D         = d_q;

    // Bound check is evaluated one bit wider than the address so the sum cannot wrap.
    assign end_addr  = {1'b0, cmd_addr} + (AW + 1)'(cmd_len);
    assign oob       = BoundChk && (end_addr > (AW + 1)'(MEM_DEPTH));

    assign rd_valid  = (cnt_q != 2'd0);
    assign rd_data   = fifo_q[rptr_q];
    assign push      = infl_q;
    assign pop       = rd_valid && rd_ready;

    // Occupancy after this cycle's pop plus the word still on its way back from the RAM;
    // counting the pop keeps one word per cycle flowing with rd_ready held high.
    assign occ       = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue     = (state_q == StRd) && (rem_q != '0) && (occ < 3'd2);

    assign wr_ready  = (state_q == StWr) && (rem_q != '0);
    assign wr_fire   = wr_valid && wr_ready;

    always_comb begin
        wptr_d = wptr_q ^ push;
        rptr_d = rptr_q ^ pop;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        a_d     = a_q;
        we_d    = 1'b0;
        oe_d    = oe_q;
        d_d     = d_q;
        infl_d  = issue;
        done_d  = (state_q == StDone);
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = StDone;
                    end else if (oob) begin
                        // Consumed but not executed: no RAM access and no done pulse.
                        err_d = 1'b1;
                        rem_d = '0;
                    end else if (cmd_write) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                        oe_d    = 1'b1;
                    end
                end
            end
            StRd: begin
                if (issue) begin
                    a_d    = addr_q;
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d = StRdDrain;
                    end
                end
            end
            StRdDrain: begin
                // Any word still in flight is captured at this edge, so OE can drop now.
                oe_d = 1'b0;
                if ((cnt_q == 2'd0) && !infl_q) begin
                    state_d = StDone;
                end
            end
            StWr: begin
                if (wr_fire) begin
                    a_d    = addr_q;
                    d_d    = wr_data;
                    we_d   = 1'b1;
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LW'(1);
                end else if (rem_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            a_q     <= '0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            d_q     <= '0;
            infl_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            cnt_q   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            a_q     <= a_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            d_q     <= d_d;
            infl_q  <= infl_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            if (push) begin
                fifo_q[wptr_q] <= Q;
            end
        end
    end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator-side controller for the team's single-port 24-bit RAM: it drives the RAM's A/WE/OE/D outputs and captures Q.
- Converts burst commands into sequential word accesses: read bursts stream out over valid/ready; write bursts consume a valid/ready stream.
- Sits between the codebook compress/decompress engines and image/codebook memory, so engines never handle RAM timing directly.

Parameters:
AW, 20, RAM address width
DW, 24, RAM data width
LW, 16, burst length field width (words)
MEM_DEPTH, 65536, physical RAM depth; used only by the optional bound check

Ports:
CK  input  1  clock; all logic on posedge
RST_N  input  1  asynchronous active-low reset
cmd_valid  input  1  burst command offered
cmd_ready  output  1  high only in IDLE with RST_N high
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  AW  start word address
cmd_len  input  LW  burst length in words; 0 = no-op
rd_valid  output  1  rd_data valid
rd_ready  input  1  consumer accepts rd_data
rd_data  output  DW  read word, in address order
wr_valid  input  1  wr_data valid
wr_ready  output  1  master accepts wr_data
wr_data  input  DW  write word
done  output  1  one-cycle pulse at burst completion
err  output  1  one-cycle pulse on rejected command (optional feature only; else tied 0)
busy  output  1  high in any state other than IDLE
A  output  AW  RAM address, registered
WE  output  1  RAM write enable, registered
OE  output  1  RAM output enable, registered
D  output  DW  RAM write data, registered
Q  input  DW  RAM read data; high-Z when OE low

Behaviour:
- Reset (async, RST_N low): state IDLE; A=0, WE=0, OE=0, D=0, rd_valid=0, wr_ready=0, done=0, err=0, busy=0, skid buffer empty, counters 0.
- RAM timing contract:
  - RAM latches A on negedge CK and drives Q combinationally while OE=1.
  - An address registered at posedge t has valid Q sampled at posedge t+1 (read latency 1 cycle).
  - WE/A/D registered at posedge t cause the RAM write at posedge t+1.
- States: IDLE, RD, RD_DRAIN, WR, DONE.
- IDLE:
  - cmd_ready=1. On cmd_valid: latch addr/len/dir.
  - len==0 -> DONE.
  - Otherwise -> RD or WR.
- RD:
  - OE=1 for the whole burst.
  - Address issue: each cycle an address issues (A<=addr, addr++, remaining--) iff remaining>0 and (skid occupancy + in-flight) < 2.
  - A word whose address issued at posedge t is pushed into the 2-entry skid FIFO at posedge t+1.
  - rd_valid = FIFO non-empty; pop on rd_valid&rd_ready.
  - Sustains 1 word/cycle while rd_ready stays high.
  - Last address issued -> RD_DRAIN.
- RD_DRAIN:
  - OE stays 1 until the final in-flight word is captured, then OE<=0.
  - Exit to DONE when FIFO empty and nothing in flight.
  - A simultaneous push and pop on the same cycle leaves occupancy unchanged.
- WR:
  - wr_ready=1 while remaining>0.
  - On wr_valid&wr_ready: A<=addr, D<=wr_data, WE<=1, addr++, remaining--. Otherwise WE<=0.
  - After the last accepted word, WE<=0 on the following cycle -> DONE.
  - WE is never asserted without a fresh word.
- DONE: done=1 for exactly one cycle -> IDLE.
- Address arithmetic: AW-bit, wraps modulo 2^AW (0xFFFFF+1 -> 0x00000).
- Command isolation: cmd_valid outside IDLE is ignored. Never both WE and OE high in the same cycle.
- Reset mid-burst: all outputs return to reset values asynchronously; partial burst abandoned; no done pulse.

Optional Feature:
- Macro: RAM_BURST_BOUND_CHK_EN.
- Defined:
  - In IDLE, a command with len>0 and cmd_addr+cmd_len > MEM_DEPTH (evaluated at AW+1 bits) is consumed but not executed.
  - err pulses 1 cycle; no RAM access; no done pulse; returns to IDLE.
- Undefined: err tied 0; all commands executed with modulo-2^AW wrap.

Test Plan:
1. Write burst addr=0x00010, len=4, data 0x111111,0x222222,0x333333,0x444444 with wr_valid always high -> WE high 4 consecutive cycles at A=0x10..0x13, done pulse follows; read burst same addr with rd_ready=1 -> rd_data 0x111111..0x444444 on consecutive cycles, done once.
2. Read len=8 with rd_ready toggling 1,0,0,1,... -> no word lost or duplicated; skid occupancy never exceeds 2; output order matches addresses 0..7.
3. cmd_len=0 (read and write) -> done pulses 2 cycles after acceptance; WE and OE stay 0.
4. Write len=3 at 0xFFFFE (macro undefined) -> writes at 0xFFFFE, 0xFFFFF, 0x00000. With macro defined, MEM_DEPTH=65536, addr=0x0FFFE, len=3 -> err pulse, no WE/OE activity, no done.
5. Deassert RST_N during the 3rd word of a len=6 read -> OE, rd_valid and busy drop immediately; after release, cmd_ready=1 and a new len=2 read returns correct data.
6. cmd_valid held high during an active burst with different addr -> ignored; only the first burst's accesses occur; second command accepted only after done.
